pc_trace_monitor: RTL and testbench
===================================

# pc_trace_monitor

Synthesizable retire monitor that replaces the ad-hoc end-of-program checks in the per-core testbenches with a parametrised block. It samples the write-back PC of any xgriscv core variant (single-cycle or pipelined), counts cycles and retired instructions, and detects program completion, hangs and timeouts. It keeps a circular history of the last DEPTH retired PCs for post-mortem debug. It sits beside the core in the top-level simulation/FPGA wrapper and drives the halt/fault status that benches and board LEDs consume.

## Interface
- XLEN, 32, PC width
- DEPTH, 8, trace history entries; power of two, >= 2
- CNT_W, 32, cycle/retire counter width
- HALT_ADDR, 32'h000000ff, PC whose retirement marks program end
- STALL_LIMIT, 16, consecutive identical retired PCs that flag a hang; >= 2
- TIMEOUT, 100000, cycles in RUN before timeout fault; must be < 2^CNT_W - 1
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous, active-high reset (asserted = 1)
- pc_valid_i  in  1  pc_i holds a retiring instruction this cycle
- pc_i  in  XLEN  write-back PC (pcW)
- rd_idx_i  in  $clog2(DEPTH)  history read index; 0 = most recent
- rd_pc_o  out  XLEN  history entry at rd_idx_i (combinational read)
- cycle_cnt_o  out  CNT_W  cycles spent in RUN
- retire_cnt_o  out  CNT_W  retired instructions
- state_o  out  2  FSM state encoding
- done_o  out  1  HALT_ADDR retired
- hang_o  out  1  stall limit reached
- timeout_o  out  1  TIMEOUT reached

## Operation
- States: IDLE=0, RUN=1, DONE=2, FAULT=3.
- IDLE -> RUN on the first pc_valid_i. That sample is processed as a normal retirement.
- RUN: every cycle cycle_cnt +1. On each pc_valid_i: retire_cnt +1, push pc_i into the history, compare with HALT_ADDR and with the previous retired PC.
- Halt: valid pc_i == HALT_ADDR -> DONE, done_o=1.
- Stall counter: resets to 1 on a valid pc_i different from the previous one. Increments on a valid pc_i equal to the previous one. Reaching STALL_LIMIT -> FAULT, hang_o=1.
- Timeout: cycle_cnt == TIMEOUT while in RUN -> FAULT, timeout_o=1.
- Priority on the same cycle: halt > hang > timeout. Only the highest-priority flag is set.
- DONE and FAULT are terminal; only reset leaves them. Counters and history are frozen there, and pc_valid_i is ignored.
- Counters saturate at all-ones and never wrap.
- History: write pointer wraps modulo DEPTH. rd_pc_o = entry (wptr-1-rd_idx_i) mod DEPTH. Entries never written read 0.
- Invalid cycles (pc_valid_i=0) update only cycle_cnt.

## Timing
- Reset values: state IDLE, all counters 0, history all 0, write pointer 0, stall counter 0, done_o/hang_o/timeout_o 0, rd_pc_o 0.
- All status outputs and counters are registered. A flag rises on the first edge after the triggering sample, and state_o changes on that same edge.
- The IDLE->RUN sample counts as retirement 1. cycle_cnt_o = 1 after that edge.
- A history write becomes visible on rd_pc_o (idx 0) on the cycle after the sampling edge.
- rstn asserted mid-run clears everything asynchronously. The first edge after deassertion samples in IDLE.
- Back-to-back valid samples are supported every cycle; no backpressure.

## Structure
- Shared package xgriscv_dbg_pkg: state enum (IDLE/RUN/DONE/FAULT), the 2-bit state width, and the default HALT_ADDR constant.
- One sub-module: pc_hist_buf, a DEPTH x XLEN circular register file with write-enable, wrapping pointer and relative read index. The top holds the FSM, counters and stall logic.

## Test plan
- Reset then a valid sequence 0x0,0x4,0x8,0xff -> done_o=1 one edge after 0xff, retire_cnt_o=4, state_o=2, rd_pc_o(idx0)=0xff, rd_pc_o(idx3)=0x0.
- PC 0x40 held valid for 16 consecutive samples (STALL_LIMIT=16) -> hang_o=1 after the 16th, done_o=0, state_o=3.
- TIMEOUT=20, valid PCs never repeating and never 0xff -> timeout_o=1 when cycle_cnt_o=20. Counters are frozen on later cycles.
- DEPTH=8, retire 0x0..0x2c (12 PCs) -> idx0=0x2c, idx7=0x10. Before wrap with 3 PCs retired, idx5 reads 0.
- 0xff sample is also the 16th repeat and at cycle TIMEOUT -> only done_o=1 (priority check).
- rstn pulsed mid-RUN with 5 retired -> all outputs 0 immediately. After release, a valid 0x0 sample returns to RUN with retire_cnt_o=1.

Source files
------------

// File: rtl/xgriscv_dbg_pkg.sv
// ----------------------------------------------------------------------------
// xgriscv_dbg_pkg
// Shared definitions for the xgriscv debug/retire monitors.
//   - mon_state_e       : retire monitor FSM state (IDLE/RUN/DONE/FAULT)
//   - STATE_W           : width of the exported state encoding
//   - DEFAULT_HALT_ADDR : PC whose retirement marks the end of a test program
// ----------------------------------------------------------------------------
package xgriscv_dbg_pkg;

    localparam int STATE_W = 2;

    localparam logic [31:0] DEFAULT_HALT_ADDR = 32'h0000_00ff;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } mon_state_e;

endpackage : xgriscv_dbg_pkg

// File: rtl/pc_hist_buf.sv
// ----------------------------------------------------------------------------
// pc_hist_buf
// Circular history of the last DEPTH retired PCs.
// Ports:
//   clk       in   core clock, rising edge
//   rstn      in   asynchronous reset, active-high (asserted = 1)
//   i_wr_en   in   push i_wr_pc at the next rising edge
//   i_wr_pc   in   PC to store
//   i_rd_idx  in   relative read index, 0 = most recently written entry
//   o_rd_pc   out  entry at i_rd_idx (combinational read)
// ----------------------------------------------------------------------------
module pc_hist_buf #(
    parameter  int XLEN  = 32,
    parameter  int DEPTH = 8,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_wr_en,
    input  logic [XLEN-1:0]  i_wr_pc,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [XLEN-1:0]  o_rd_pc
);

    logic [XLEN-1:0]  r_mem [DEPTH];
    logic [IDX_W-1:0] r_wptr;
    logic [IDX_W-1:0] w_rd_addr;

    // NOTE: the storage is reset on purpose: entries never written must read
    // back as 0, so this is a register file, not an inferred RAM.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_wptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[r_wptr] <= i_wr_pc;
            r_wptr        <= r_wptr + 1'b1;  // wraps naturally, DEPTH is 2^IDX_W
        end
    end

    // Newest entry sits just below the write pointer; the subtraction wraps
    // modulo DEPTH for the same power-of-two reason.
    assign w_rd_addr = r_wptr - 1'b1 - i_rd_idx;
    assign o_rd_pc   = r_mem[w_rd_addr];

endmodule : pc_hist_buf

// File: rtl/pc_trace_monitor.sv
// ----------------------------------------------------------------------------
// pc_trace_monitor
// Retire monitor for xgriscv cores. Samples the write-back PC, counts cycles
// and retirements, and flags program completion (HALT_ADDR retired), hangs
// (STALL_LIMIT identical consecutive retired PCs) and timeouts (TIMEOUT cycles
// in RUN). Keeps the last DEPTH retired PCs for post-mortem inspection.
// Ports:
//   clk           in   core clock, rising edge
//   rstn          in   asynchronous reset, ACTIVE-HIGH despite its name
//   pc_valid_i    in   pc_i holds a retiring instruction this cycle
//   pc_i          in   write-back PC
//   rd_idx_i      in   history read index, 0 = most recent
//   rd_pc_o       out  history entry at rd_idx_i (combinational)
//   cycle_cnt_o   out  cycles spent in RUN (saturating)
//   retire_cnt_o  out  retired instructions (saturating)
//   state_o       out  FSM state (IDLE=0, RUN=1, DONE=2, FAULT=3)
//   done_o        out  HALT_ADDR retired
//   hang_o        out  stall limit reached
//   timeout_o     out  TIMEOUT reached
// ----------------------------------------------------------------------------
module pc_trace_monitor
    import xgriscv_dbg_pkg::*;
#(
    parameter  int              XLEN        = 32,
    parameter  int              DEPTH       = 8,
    parameter  int              CNT_W       = 32,
    parameter  logic [XLEN-1:0] HALT_ADDR   = XLEN'(DEFAULT_HALT_ADDR),
    parameter  int              STALL_LIMIT = 16,
    parameter  int              TIMEOUT     = 100000,
    localparam int              IDX_W       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pc_valid_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [IDX_W-1:0]   rd_idx_i,
    output logic [XLEN-1:0]    rd_pc_o,
    output logic [CNT_W-1:0]   cycle_cnt_o,
    output logic [CNT_W-1:0]   retire_cnt_o,
    output logic [STATE_W-1:0] state_o,
    output logic               done_o,
    output logic               hang_o,
    output logic               timeout_o
);

    // The stall counter never needs to exceed STALL_LIMIT: reaching it ends RUN.
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);

    mon_state_e       r_state;
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [XLEN-1:0]  r_last_pc;
    logic             r_done;
    logic             r_hang;
    logic             r_timeout;

    logic               w_active;
    logic               w_accept;
    logic [CNT_W-1:0]   w_cycle_next;
    logic [CNT_W-1:0]   w_retire_next;
    logic [STALL_W-1:0] w_stall_next;
    logic               w_halt;
    logic               w_hang;
    logic               w_timeout;

    // The IDLE->RUN sample is a full RUN cycle: it counts as cycle 1 and
    // retirement 1, and is checked for halt/hang/timeout like any other.
    assign w_active = (r_state == ST_RUN) || ((r_state == ST_IDLE) && pc_valid_i);
    assign w_accept = w_active && pc_valid_i;

    assign w_cycle_next  = (r_cycle_cnt  == '1) ? r_cycle_cnt  : r_cycle_cnt  + 1'b1;
    assign w_retire_next = (r_retire_cnt == '1) ? r_retire_cnt : r_retire_cnt + 1'b1;

    // First retirement has no predecessor, so it always starts a new run of 1.
    assign w_stall_next = ((r_state == ST_RUN) && (pc_i == r_last_pc))
                        ? r_stall_cnt + 1'b1
                        : STALL_W'(1);

    assign w_halt    = w_accept && (pc_i == HALT_ADDR);
    assign w_hang    = w_accept && (w_stall_next == STALL_W'(STALL_LIMIT));
    assign w_timeout = w_active && (w_cycle_next == CNT_W'(TIMEOUT));

    // NOTE: all state here is updated with non-blocking assignments so every
    // register sees the pre-edge values of its neighbours, as the hardware does.
    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state      <= ST_IDLE;
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
            r_stall_cnt  <= '0;
            r_last_pc    <= '0;
            r_done       <= 1'b0;
            r_hang       <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RUN: begin
                    if (w_active) begin
                        r_cycle_cnt <= w_cycle_next;
                        if (pc_valid_i) begin
                            r_retire_cnt <= w_retire_next;
                            r_stall_cnt  <= w_stall_next;
                            r_last_pc    <= pc_i;
                        end
                        // Priority halt > hang > timeout; only one flag rises.
                        if (w_halt) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else if (w_hang) begin
                            r_state <= ST_FAULT;
                            r_hang  <= 1'b1;
                        end else if (w_timeout) begin
                            r_state   <= ST_FAULT;
                            r_timeout <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: begin
                    // DONE and FAULT are terminal: everything stays frozen.
                end
            endcase
        end
    end

    pc_hist_buf #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_hist (
        .clk      (clk),
        .rstn     (rstn),
        .i_wr_en  (w_accept),
        .i_wr_pc  (pc_i),
        .i_rd_idx (rd_idx_i),
        .o_rd_pc  (rd_pc_o)
    );

    assign cycle_cnt_o  = r_cycle_cnt;
    assign retire_cnt_o = r_retire_cnt;
    assign state_o      = r_state;
    assign done_o       = r_done;
    assign hang_o       = r_hang;
    assign timeout_o    = r_timeout;

endmodule : pc_trace_monitor

// File: tb/tb_pc_trace_monitor.sv
// ----------------------------------------------------------------------------
// tb_pc_trace_monitor
// Three monitors share one stimulus stream and differ only in TIMEOUT
// (100000, 20, 16). Each is checked against a reference model built on the
// full list of retired PCs: every monitor's history is a prefix of that list,
// the stall count is the length of its trailing run of equal PCs, and history
// entry i is simply the i-th most recent element.
// ----------------------------------------------------------------------------
module tb_pc_trace_monitor;

    localparam int          NI   = 3;
    localparam logic [31:0] HALT = 32'h0000_00ff;
    localparam int          SL   = 16;

    logic        clk;
    logic        rstn;
    logic        pc_valid;
    logic [31:0] pc;
    logic [2:0]  rd_idx;

    logic [31:0] rd_pc_o   [NI];
    logic [31:0] cycle_o   [NI];
    logic [31:0] retire_o  [NI];
    logic [1:0]  state_o   [NI];
    logic        done_o    [NI];
    logic        hang_o    [NI];
    logic        timeout_o [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        pc_trace_monitor #(
            .TIMEOUT((g == 0) ? 100000 : (g == 1) ? 20 : 16)
        ) u_dut (
            .clk          (clk),
            .rstn         (rstn),
            .pc_valid_i   (pc_valid),
            .pc_i         (pc),
            .rd_idx_i     (rd_idx),
            .rd_pc_o      (rd_pc_o[g]),
            .cycle_cnt_o  (cycle_o[g]),
            .retire_cnt_o (retire_o[g]),
            .state_o      (state_o[g]),
            .done_o       (done_o[g]),
            .hang_o       (hang_o[g]),
            .timeout_o    (timeout_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [31:0] seq[$];          // every PC retired by any still-active monitor
    int          m_n   [NI];      // length of each monitor's retired prefix
    int          m_cyc [NI];
    int          m_st  [NI];      // 0 idle, 1 run, 2 done, 3 fault
    bit          m_done[NI];
    bit          m_hang[NI];
    bit          m_to  [NI];
    int          to_lim[NI] = '{100000, 20, 16};

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    function automatic int run_len(input int n);
        int r = 1;
        for (int j = n - 2; j >= 0; j--) begin
            if (seq[j] == seq[n-1]) r++;
            else break;
        end
        return r;
    endfunction

    task automatic model_reset();
        seq.delete();
        for (int k = 0; k < NI; k++) begin
            m_n[k] = 0; m_cyc[k] = 0; m_st[k] = 0;
            m_done[k] = 0; m_hang[k] = 0; m_to[k] = 0;
        end
    endtask

    task automatic model_step(input bit v, input logic [31:0] p);
        bit act [NI];
        bit any = 0;
        for (int k = 0; k < NI; k++) begin
            act[k] = (m_st[k] == 1) || (m_st[k] == 0 && v);
            any |= act[k];
        end
        if (v && any) seq.push_back(p);
        for (int k = 0; k < NI; k++) begin
            if (act[k]) begin
                bit halt, hang, tmo;
                m_cyc[k]++;
                if (v) m_n[k]++;
                halt = v && (p == HALT);
                hang = v && (run_len(m_n[k]) >= SL);
                tmo  = (m_cyc[k] == to_lim[k]);
                if (halt)      begin m_st[k] = 2; m_done[k] = 1; end
                else if (hang) begin m_st[k] = 3; m_hang[k] = 1; end
                else if (tmo)  begin m_st[k] = 3; m_to[k]   = 1; end
                else           m_st[k] = 1;
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_hist(input int k, input int idx);
        return (idx < m_n[k]) ? seq[m_n[k]-1-idx] : 32'h0;
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < NI; k++) begin
            check($sformatf("%s.u%0d.state", tag, k),   32'(state_o[k]),   32'(m_st[k]));
            check($sformatf("%s.u%0d.done", tag, k),    32'(done_o[k]),    32'(m_done[k]));
            check($sformatf("%s.u%0d.hang", tag, k),    32'(hang_o[k]),    32'(m_hang[k]));
            check($sformatf("%s.u%0d.timeout", tag, k), 32'(timeout_o[k]), 32'(m_to[k]));
            check($sformatf("%s.u%0d.cycle", tag, k),   cycle_o[k],        32'(m_cyc[k]));
            check($sformatf("%s.u%0d.retire", tag, k),  retire_o[k],       32'(m_n[k]));
            check($sformatf("%s.u%0d.rdpc[%0d]", tag, k, rd_idx), rd_pc_o[k], exp_hist(k, int'(rd_idx)));
        end
    endtask

    task automatic check_hist(input string tag, input int k, input int idx, input logic [31:0] exp);
        rd_idx = 3'(idx);
        #1;
        check($sformatf("%s.u%0d.idx%0d", tag, k, idx), rd_pc_o[k], exp);
    endtask

    // Drive at negedge, let one rising edge pass, check at negedge + 1.
    task automatic step(input string tag, input bit v, input logic [31:0] p);
        pc_valid = v;
        pc       = p;
        @(posedge clk);
        model_step(v, p);
        @(negedge clk);
        pc_valid = 1'b0;
        rd_idx   = 3'($urandom_range(0, 7));
        #1;
        check_all(tag);
    endtask

    // Asynchronous reset: outputs must clear without any clock edge.
    task automatic do_reset(input string tag);
        rstn     = 1'b1;
        pc_valid = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        rstn = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] last_pc;
        rstn = 1'b1; pc_valid = 1'b0; pc = '0; rd_idx = '0;
        model_reset();

        // 1) reset state
        do_reset("reset");
        check("reset.u0.retire_zero", retire_o[0], 32'h0);

        // 2) basic halt sequence
        step("halt", 1'b1, 32'h0);
        step("halt", 1'b1, 32'h4);
        step("halt", 1'b1, 32'h8);
        step("halt", 1'b1, 32'hff);
        check("halt.u0.done", 32'(done_o[0]), 32'h1);
        check("halt.u0.retire", retire_o[0], 32'd4);
        check("halt.u0.state", 32'(state_o[0]), 32'd2);
        check_hist("halt", 0, 0, 32'hff);
        check_hist("halt", 0, 3, 32'h0);
        step("halt.frozen", 1'b1, 32'h4);
        check("halt.frozen.u0.retire", retire_o[0], 32'd4);

        // 3) hang: 0x40 sixteen times; on u2 the 16th is also cycle TIMEOUT
        do_reset("rst2");
        for (int i = 0; i < SL; i++) step("hang", 1'b1, 32'h40);
        check("hang.u0.hang", 32'(hang_o[0]), 32'h1);
        check("hang.u0.done", 32'(done_o[0]), 32'h0);
        check("hang.u0.state", 32'(state_o[0]), 32'd3);
        check("hang.u2.hang", 32'(hang_o[2]), 32'h1);
        check("hang.u2.timeout", 32'(timeout_o[2]), 32'h0);

        // 4) timeout: never-repeating PCs, random valid gaps
        do_reset("rst3");
        step("tmo", 1'b1, 32'h1000);
        for (int i = 1; i < 30; i++)
            step("tmo", 1'($urandom_range(0, 1)), 32'h1000 + 32'(4 * i));
        check("tmo.u1.timeout", 32'(timeout_o[1]), 32'h1);
        check("tmo.u1.cycle", cycle_o[1], 32'd20);
        check("tmo.u2.cycle", cycle_o[2], 32'd16);
        check("tmo.u0.state", 32'(state_o[0]), 32'd1);

        // 5) history wrap
        do_reset("rst4");
        for (int i = 0; i < 3; i++) step("hist", 1'b1, 32'(4 * i));
        check_hist("hist.prewrap", 0, 5, 32'h0);
        for (int i = 3; i < 12; i++) step("hist", 1'b1, 32'(4 * i));
        check_hist("hist.wrap", 0, 0, 32'h2c);
        check_hist("hist.wrap", 0, 7, 32'h10);

        // 6) halt and timeout on the same edge (u1, TIMEOUT=20)
        do_reset("rst5");
        step("prio", 1'b1, 32'h100);
        for (int i = 2; i < 20; i++)
            step("prio", 1'($urandom_range(0, 1)), 32'h200 + 32'(4 * i));
        step("prio", 1'b1, 32'hff);
        check("prio.u1.done", 32'(done_o[1]), 32'h1);
        check("prio.u1.timeout", 32'(timeout_o[1]), 32'h0);
        check("prio.u1.cycle", cycle_o[1], 32'd20);
        step("prio.frozen", 1'b1, 32'h300);

        // 7) reset pulse mid-run after 5 retirements
        do_reset("rst6");
        for (int i = 0; i < 5; i++) step("mid", 1'b1, 32'(4 * i));
        do_reset("midrst");
        check("midrst.u0.retire", retire_o[0], 32'h0);
        step("after", 1'b1, 32'h0);
        check("after.u0.retire", retire_o[0], 32'd1);
        check("after.u0.state", 32'(state_o[0]), 32'd1);

        // 8) randomized episodes with biased repeats and rare halts
        for (int e = 0; e < 5; e++) begin
            do_reset("rnd.rst");
            last_pc = 32'(4 * $urandom_range(0, 15));
            for (int i = 0; i < 50; i++) begin
                int r = $urandom_range(0, 99);
                if (r >= 85 && r < 87)  last_pc = HALT;
                else if (r >= 87)       last_pc = 32'(4 * $urandom_range(0, 15));
                step("rnd", 1'($urandom_range(0, 3) != 0), last_pc);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pc_trace_monitor
